// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode, ALUOp and ID/EX control-bit definitions for the MIPS-32 decode stage
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int CTRL_W        = 9;
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  // Opcode to ex_ctrl; j and unknown opcodes carry no EX-side control
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] op);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c[CTRL_REGDST]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_FUNCT;
      end
      OP_LW: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_MEMTOREG] = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_MEMREAD]  = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
      end
      OP_SW: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_MEMWRITE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
      end
      OP_BEQ: begin
        c[CTRL_BRANCH]   = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_SUB;
      end
      OP_ADDI: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file with write-through bypass and $0 hardwired to zero
module register_file #(
  parameter int DATA_W   = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ADDR-1:0] ra1_i,
  input  logic [REG_ADDR-1:0] ra2_i,
  output logic [DATA_W-1:0]   rd1_o,
  output logic [DATA_W-1:0]   rd2_o,
  input  logic                we_i,
  input  logic [REG_ADDR-1:0] wa_i,
  input  logic [DATA_W-1:0]   wd_i
);

  localparam int NREG = 1 << REG_ADDR;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_en;

  assign wr_en = we_i && (wa_i != '0);

  // Storage: cleared on reset, writes to $0 dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Async reads; a same-cycle WB write to the read index is forwarded
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
    if (wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-32 ID stage: control decode, register read, load-use hazard, jump, ID/EX register
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         Instruccion,
  input  logic [DATA_W-1:0]   Adder,
  input  logic                flush,
  input  logic                wb_reg_write,
  input  logic [REG_ADDR-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]   wb_write_data,
  output logic                stall,
  output logic                jump,
  output logic [DATA_W-1:0]   jump_address,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic [DATA_W-1:0]   ex_adder,
  output logic [DATA_W-1:0]   ex_rd1,
  output logic [DATA_W-1:0]   ex_rd2,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [REG_ADDR-1:0] ex_rt,
  output logic [REG_ADDR-1:0] ex_rd,
  output logic [5:0]          ex_funct
);

  logic [5:0]          opcode;
  logic [REG_ADDR-1:0] rs, rt, rd;
  logic [15:0]         imm;
  logic [CTRL_W-1:0]   ctrl_dec;
  logic [DATA_W-1:0]   rf_rd1, rf_rd2;
  logic                reads_rs, uses_rt;

  logic [CTRL_W-1:0]   ex_ctrl_q,  ex_ctrl_d;
  logic [DATA_W-1:0]   ex_adder_q, ex_adder_d;
  logic [DATA_W-1:0]   ex_rd1_q,   ex_rd1_d;
  logic [DATA_W-1:0]   ex_rd2_q,   ex_rd2_d;
  logic [DATA_W-1:0]   ex_imm_q,   ex_imm_d;
  logic [REG_ADDR-1:0] ex_rt_q,    ex_rt_d;
  logic [REG_ADDR-1:0] ex_rd_q,    ex_rd_d;
  logic [5:0]          ex_funct_q, ex_funct_d;

  assign opcode   = Instruccion[31:26];
  assign rs       = Instruccion[25:21];
  assign rt       = Instruccion[20:16];
  assign rd       = Instruccion[15:11];
  assign imm      = Instruccion[15:0];
  assign ctrl_dec = decode_ctrl(opcode);

  register_file #(
    .DATA_W  (DATA_W),
    .REG_ADDR(REG_ADDR)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .ra1_i(rs),
    .ra2_i(rt),
    .rd1_o(rf_rd1),
    .rd2_o(rf_rd2),
    .we_i (wb_reg_write),
    .wa_i (wb_write_reg),
    .wd_i (wb_write_data)
  );

  // Which register operands the instruction in ID actually consumes
  always_comb begin
    reads_rs = 1'b0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE, OP_SW, OP_BEQ: begin
        reads_rs = 1'b1;
        uses_rt  = 1'b1;
      end
      OP_LW, OP_ADDI: reads_rs = 1'b1;
      default: ;
    endcase
  end

  // Load-use hazard against the load now in EX; a flush makes the stall moot
  always_comb begin
    stall = ex_ctrl_q[CTRL_MEMREAD] && (ex_rt_q != '0) &&
            (((ex_rt_q == rs) && reads_rs) || ((ex_rt_q == rt) && uses_rt)) &&
            !flush;
  end

  assign jump         = (opcode == OP_J) && !flush;
  assign jump_address = {Adder[DATA_W-1:DATA_W-4], Instruccion[25:0], 2'b00};

  // Next ID/EX contents; flush or stall turns the slot into a bubble
  always_comb begin
    ex_ctrl_d  = ctrl_dec;
    ex_adder_d = Adder;
    ex_rd1_d   = rf_rd1;
    ex_rd2_d   = rf_rd2;
    ex_imm_d   = {{(DATA_W-16){imm[15]}}, imm};
    ex_rt_d    = rt;
    ex_rd_d    = rd;
    ex_funct_d = Instruccion[5:0];
    if (flush || stall) ex_ctrl_d = '0;
  end

  // ID/EX pipeline register, reset to a NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q  <= '0;
      ex_adder_q <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_funct_q <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_adder_q <= ex_adder_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_imm_q   <= ex_imm_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      ex_funct_q <= ex_funct_d;
    end
  end

  assign ex_ctrl  = ex_ctrl_q;
  assign ex_adder = ex_adder_q;
  assign ex_rd1   = ex_rd1_q;
  assign ex_rd2   = ex_rd2_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rt    = ex_rt_q;
  assign ex_rd    = ex_rd_q;
  assign ex_funct = ex_funct_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] Instruccion;
  logic [31:0] Adder;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        stall;
  logic        jump;
  logic [31:0] jump_address;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_adder;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_funct;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] C_R    = 9'b100100010;
  localparam logic [8:0] C_LW   = 9'b011110000;
  localparam logic [8:0] C_SW   = 9'b010001000;
  localparam logic [8:0] C_BEQ  = 9'b000000101;
  localparam logic [8:0] C_ADDI = 9'b010100000;

  decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .Instruccion  (Instruccion),
    .Adder        (Adder),
    .flush        (flush),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .wb_write_data(wb_write_data),
    .stall        (stall),
    .jump         (jump),
    .jump_address (jump_address),
    .ex_ctrl      (ex_ctrl),
    .ex_adder     (ex_adder),
    .ex_rd1       (ex_rd1),
    .ex_rd2       (ex_rd2),
    .ex_imm       (ex_imm),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_funct     (ex_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h0000_1234;
    Instruccion = 32'h00A5_3020; Adder = 32'h0000_0044;
    tick();
    checks++; if (ex_ctrl !== 9'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", ex_ctrl, 9'h0); end
    checks++; if (ex_adder !== 32'h0) begin errors++; $display("FAIL reset_adder got %h exp %h", ex_adder, 32'h0); end
    checks++; if ({ex_rd1, ex_rd2, ex_imm} !== 96'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", ex_rd1, ex_rd2, ex_imm); end
    checks++; if ({ex_rt, ex_rd, ex_funct} !== 16'h0) begin errors++; $display("FAIL reset_fields got %h %h %h exp 0", ex_rt, ex_rd, ex_funct); end
    rst = 1'b0; wb_reg_write = 1'b0;
    tick();
    checks++; if (ex_rd1 !== 32'h0) begin errors++; $display("FAIL reset_r5_read got %h exp %h", ex_rd1, 32'h0); end
    checks++; if (ex_ctrl !== C_R) begin errors++; $display("FAIL reset_add_ctrl got %h exp %h", ex_ctrl, C_R); end
    checks++; if (ex_rd !== 5'd6) begin errors++; $display("FAIL reset_add_rd got %h exp %h", ex_rd, 5'd6); end
  endtask

  task automatic test_bypass();
    wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'h0000_00AA;
    Instruccion = 32'h0063_2020; Adder = 32'h0000_0100;
    tick();
    checks++; if (ex_rd1 !== 32'hAA) begin errors++; $display("FAIL bypass_rd1 got %h exp %h", ex_rd1, 32'hAA); end
    checks++; if (ex_rd2 !== 32'hAA) begin errors++; $display("FAIL bypass_rd2 got %h exp %h", ex_rd2, 32'hAA); end
    checks++; if (ex_ctrl !== C_R) begin errors++; $display("FAIL bypass_ctrl got %h exp %h", ex_ctrl, C_R); end
    checks++; if (ex_adder !== 32'h100) begin errors++; $display("FAIL bypass_adder got %h exp %h", ex_adder, 32'h100); end
    checks++; if ({ex_rd, ex_funct} !== {5'd4, 6'h20}) begin errors++; $display("FAIL bypass_rd_funct got %h %h exp 4 20", ex_rd, ex_funct); end
    wb_reg_write = 1'b0;
    tick();
    checks++; if (ex_rd1 !== 32'hAA) begin errors++; $display("FAIL stored_r3 got %h exp %h", ex_rd1, 32'hAA); end
  endtask

  task automatic test_zero_reg();
    wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'hFFFF_FFFF;
    Instruccion = 32'h0000_2020;
    tick();
    checks++; if (ex_rd1 !== 32'h0) begin errors++; $display("FAIL zero_bypass got %h exp %h", ex_rd1, 32'h0); end
    wb_reg_write = 1'b0;
    tick();
    checks++; if (ex_rd2 !== 32'h0) begin errors++; $display("FAIL zero_stored got %h exp %h", ex_rd2, 32'h0); end
  endtask

  task automatic test_load_use();
    wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'h0000_0010;
    Instruccion = 32'h8C22_0000; Adder = 32'h0000_0200;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_no_stall got %b exp 0", stall); end
    tick();
    wb_reg_write = 1'b0;
    checks++; if (ex_ctrl !== C_LW) begin errors++; $display("FAIL lw_ctrl got %h exp %h", ex_ctrl, C_LW); end
    checks++; if ({ex_rd1, ex_rt} !== {32'h10, 5'd2}) begin errors++; $display("FAIL lw_rd1_rt got %h %h exp 10 2", ex_rd1, ex_rt); end
    Instruccion = 32'h0042_2820;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b exp 1", stall); end
    tick();
    checks++; if (ex_ctrl !== 9'h0) begin errors++; $display("FAIL bubble_ctrl got %h exp %h", ex_ctrl, 9'h0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_one_cycle got %b exp 0", stall); end
    tick();
    checks++; if ({ex_ctrl, ex_rd} !== {C_R, 5'd5}) begin errors++; $display("FAIL after_bubble got %h %h exp %h 5", ex_ctrl, ex_rd, C_R); end
    Instruccion = 32'h8C22_0000;
    tick();
    Instruccion = 32'h2062_0001;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL addi_rt_no_stall got %b exp 0", stall); end
    tick();
    checks++; if (ex_ctrl !== C_ADDI) begin errors++; $display("FAIL addi_after_lw got %h exp %h", ex_ctrl, C_ADDI); end
  endtask

  task automatic test_jump_flush();
    Instruccion = 32'h0800_0010; Adder = 32'h4000_0008;
    #1;
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL jump got %b exp 1", jump); end
    checks++; if (jump_address !== 32'h4000_0040) begin errors++; $display("FAIL jump_addr got %h exp %h", jump_address, 32'h4000_0040); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jump_stall got %b exp 0", stall); end
    tick();
    checks++; if ({ex_ctrl, ex_adder} !== {9'h0, 32'h4000_0008}) begin errors++; $display("FAIL jump_idex got %h %h exp 0 40000008", ex_ctrl, ex_adder); end
    flush = 1'b1;
    #1;
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL jump_flushed got %b exp 0", jump); end
    tick();
    checks++; if (ex_ctrl !== 9'h0) begin errors++; $display("FAIL jump_flush_ctrl got %h exp 0", ex_ctrl); end
    flush = 1'b0; Instruccion = 32'h8C22_0000;
    tick();
    Instruccion = 32'h0042_2820; flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_kills_stall got %b exp 0", stall); end
    tick();
    checks++; if (ex_ctrl !== 9'h0) begin errors++; $display("FAIL flush_ctrl got %h exp 0", ex_ctrl); end
    flush = 1'b0;
  endtask

  task automatic test_imm_decode();
    Instruccion = 32'h2001_FFFC;
    tick();
    checks++; if (ex_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL addi_imm got %h exp %h", ex_imm, 32'hFFFF_FFFC); end
    checks++; if ({ex_ctrl, ex_rt} !== {C_ADDI, 5'd1}) begin errors++; $display("FAIL addi_ctrl_rt got %h %h exp %h 1", ex_ctrl, ex_rt, C_ADDI); end
    Instruccion = 32'hAC22_0004;
    tick();
    checks++; if ({ex_ctrl, ex_imm} !== {C_SW, 32'h4}) begin errors++; $display("FAIL sw got %h %h exp %h 4", ex_ctrl, ex_imm, C_SW); end
    Instruccion = 32'h1022_7FFF;
    tick();
    checks++; if ({ex_ctrl, ex_imm} !== {C_BEQ, 32'h7FFF}) begin errors++; $display("FAIL beq got %h %h exp %h 7fff", ex_ctrl, ex_imm, C_BEQ); end
    Instruccion = 32'hFC00_0000;
    tick();
    checks++; if (ex_ctrl !== 9'h0) begin errors++; $display("FAIL unknown_op got %h exp 0", ex_ctrl); end
  endtask

  task automatic test_reset_midrun();
    Instruccion = 32'h0063_2020; Adder = 32'h0000_0300; rst = 1'b1;
    tick();
    checks++; if ({ex_ctrl, ex_adder} !== 41'h0) begin errors++; $display("FAIL midrun_reset got %h %h exp 0", ex_ctrl, ex_adder); end
    rst = 1'b0;
    tick();
    checks++; if (ex_rd1 !== 32'h0) begin errors++; $display("FAIL regs_cleared got %h exp 0", ex_rd1); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_load_use();
    test_jump_flush();
    test_imm_decode();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
